// File: rtl/alu_pkg.sv
// Shared execute-stage definitions: ALU control codes, RV32 opcode and
// funct3/funct7 constants, the sequencer state enum and the decode record.
// The datapath ALU imports the same control codes.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_MUL = 4'b0010,
    ALU_NOP = 4'b1111
  } alu_ctrl_e;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Result of decoding one instruction.
  typedef struct packed {
    alu_ctrl_e ctrl;
    logic      use_imm;  // operand B is the immediate
    logic      is_br;    // BEQ or BNE
    logic      is_bne;
    logic      ill;
  } dec_t;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer in front of the datapath ALU.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          instruction handshake (opcode, funct3, funct7,
//                              rs1_val, rs2_val, imm, pc)
//   alu_a, alu_b, alu_control  registered ALU operands and op code
//   alu_result, alu_zero       combinational ALU outputs
//   out_valid/out_ready        response handshake (out_result, branch_taken,
//                              branch_target, illegal)
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            illegal
);

  localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

  function automatic dec_t decode(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7);
    dec_t d;
    d = '{ctrl: ALU_NOP, use_imm: 1'b0, is_br: 1'b0, is_bne: 1'b0, ill: 1'b1};
    if (op == OP_R && f3 == F3_ADD) begin
      if (f7 == F7_ADD)      d = '{ctrl: ALU_ADD, use_imm: 1'b0, is_br: 1'b0, is_bne: 1'b0, ill: 1'b0};
      else if (f7 == F7_SUB) d = '{ctrl: ALU_SUB, use_imm: 1'b0, is_br: 1'b0, is_bne: 1'b0, ill: 1'b0};
      else if (f7 == F7_MUL) d = '{ctrl: ALU_MUL, use_imm: 1'b0, is_br: 1'b0, is_bne: 1'b0, ill: 1'b0};
    end else if (op == OP_I && f3 == F3_ADD) begin
      d = '{ctrl: ALU_ADD, use_imm: 1'b1, is_br: 1'b0, is_bne: 1'b0, ill: 1'b0};
    end else if (op == OP_B && (f3 == F3_BEQ || f3 == F3_BNE)) begin
      d = '{ctrl: ALU_SUB, use_imm: 1'b0, is_br: 1'b1, is_bne: (f3 == F3_BNE), ill: 1'b0};
    end
    return d;
  endfunction

  state_e          state_q, state_d;
  logic [3:0]      cnt_q;
  logic [XLEN-1:0] alu_a_q, alu_b_q, tgt_q;
  alu_ctrl_e       ctrl_q;
  logic            is_br_q, is_bne_q, ill_ctx_q;
  logic [XLEN-1:0] res_q, btgt_q;
  logic            btaken_q, ill_q;
  dec_t            dec;
  logic            accept, exec_done;

  assign dec       = decode(opcode, funct3, funct7);
  assign accept    = (state_q == ST_IDLE) && in_valid;
  // MUL holds EXEC for MUL_LAT cycles; everything else for one.
  assign exec_done = (state_q == ST_EXEC) &&
                     (cnt_q == ((ctrl_q == ALU_MUL) ? MUL_LAST : 4'd0));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_EXEC;
      ST_EXEC: if (exec_done) state_d = ST_RESP;
      ST_RESP: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      ctrl_q    <= ALU_ADD;
      tgt_q     <= '0;
      is_br_q   <= 1'b0;
      is_bne_q  <= 1'b0;
      ill_ctx_q <= 1'b0;
      res_q     <= '0;
      btaken_q  <= 1'b0;
      btgt_q    <= '0;
      ill_q     <= 1'b0;
    end else if (accept) begin
      cnt_q     <= '0;
      alu_a_q   <= dec.ill ? '0 : rs1_val;
      alu_b_q   <= dec.ill ? '0 : (dec.use_imm ? imm : rs2_val);
      ctrl_q    <= dec.ctrl;
      tgt_q     <= dec.is_br ? (pc + imm) : '0;
      is_br_q   <= dec.is_br;
      is_bne_q  <= dec.is_bne;
      ill_ctx_q <= dec.ill;
    end else if (state_q == ST_EXEC) begin
      cnt_q <= cnt_q + 4'd1;
      if (exec_done) begin
        res_q    <= (is_br_q || ill_ctx_q) ? '0 : alu_result;
        btaken_q <= is_br_q && (is_bne_q ? !alu_zero : alu_zero);
        btgt_q   <= tgt_q;
        ill_q    <= ill_ctx_q;
      end
    end
  end

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_control   = ctrl_q;
  assign out_result    = res_q;
  assign branch_taken  = btaken_q;
  assign branch_target = btgt_q;
  assign illegal       = ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val, rs2_val, imm, pc;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic [3:0]      alu_control;
  logic            alu_zero;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_result, branch_target;
  logic            branch_taken, illegal;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc(pc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .branch_taken(branch_taken), .branch_target(branch_target), .illegal(illegal)
  );

  // Behavioural datapath ALU sitting beside the sequencer.
  always_comb begin
    case (alu_control)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a * alu_b;
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  typedef struct {
    logic [31:0] a, b, res, tgt;
    logic [3:0]  ctrl;
    logic        bt, ill;
    int          lat;
  } exp_t;

  // Reference: what the instruction means architecturally.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic [31:0] im,
                                 input logic [31:0] p);
    exp_t e;
    e.a = 0; e.b = 0; e.res = 0; e.tgt = 0; e.ctrl = 4'hF; e.bt = 0; e.ill = 1; e.lat = 1;
    if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) begin
      e.a = r1; e.b = r2; e.ctrl = 4'h0; e.res = r1 + r2; e.ill = 0;
    end else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) begin
      e.a = r1; e.b = r2; e.ctrl = 4'h1; e.res = r1 - r2; e.ill = 0;
    end else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h01) begin
      e.a = r1; e.b = r2; e.ctrl = 4'h2; e.res = r1 * r2; e.ill = 0; e.lat = MUL_LAT;
    end else if (op == 7'h13 && f3 == 3'd0) begin
      e.a = r1; e.b = im; e.ctrl = 4'h0; e.res = r1 + im; e.ill = 0;
    end else if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin
      e.a = r1; e.b = r2; e.ctrl = 4'h1; e.ill = 0; e.tgt = p + im;
      e.bt = (f3 == 3'd0) ? (r1 == r2) : (r1 != r2);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_alu_control"}, 32'(alu_control), 32'd0);
    chk({tag, "_out_result"}, out_result, 32'd0);
    chk({tag, "_branch_taken"}, 32'(branch_taken), 32'd0);
    chk({tag, "_branch_target"}, branch_target, 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
  endtask

  // One full transaction with timing and value checks. hold = cycles of
  // out_ready low in RESP; busy = pulse in_valid during the first EXEC cycle.
  task automatic txn(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] r1, input logic [31:0] r2,
                     input logic [31:0] im, input logic [31:0] p, input int hold,
                     input bit busy);
    exp_t e;
    int guard;
    e = model(op, f3, f7, r1, r2, im, p);
    guard = 0;
    while (!in_ready && guard < 20) begin tick(); guard++; end
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1; opcode = op; funct3 = f3; funct7 = f7;
    rs1_val = r1; rs2_val = r2; imm = im; pc = p;
    tick();
    in_valid = 0;
    chk({tag, "_ctrl"}, 32'(alu_control), 32'(e.ctrl));
    chk({tag, "_alu_a"}, alu_a, e.a);
    chk({tag, "_alu_b"}, alu_b, e.b);
    for (int i = 0; i < e.lat; i++) begin
      chk({tag, "_exec_no_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_exec_busy"}, 32'(in_ready), 32'd0);
      chk({tag, "_exec_ctrl_stable"}, 32'(alu_control), 32'(e.ctrl));
      if (i == 0 && busy) begin
        in_valid = 1; opcode = 7'h33; funct3 = 0; funct7 = 7'h20;
        rs1_val = 32'hDEAD; rs2_val = 32'hBEEF;
      end
      tick();
      in_valid = 0;
    end
    for (int h = 0; h <= hold; h++) begin
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_resp_busy"}, 32'(in_ready), 32'd0);
      chk({tag, "_result"}, out_result, e.res);
      chk({tag, "_taken"}, 32'(branch_taken), 32'(e.bt));
      chk({tag, "_target"}, branch_target, e.tgt);
      chk({tag, "_illegal"}, 32'(illegal), 32'(e.ill));
      out_ready = (h == hold);
      tick();
    end
    out_ready = 0;
    chk({tag, "_back_idle"}, 32'(in_ready), 32'd1);
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    if (busy) begin
      tick();
      chk({tag, "_busy_not_latched"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 0;
    opcode = 0; funct3 = 0; funct7 = 0;
    rs1_val = 0; rs2_val = 0; imm = 0; pc = 0;
    repeat (3) tick();
    chk_reset_outputs("rst");
    rst_n = 1;
    tick();
    chk_reset_outputs("post_rst");

    txn("add",  7'h33, 3'd0, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0, 0, 1'b0);
    txn("mulw", 7'h33, 3'd0, 7'h01, 32'h10000, 32'h10000, 32'd0, 32'd0, 0, 1'b0);
    txn("mul",  7'h33, 3'd0, 7'h01, 32'd6, 32'd7, 32'd0, 32'd0, 0, 1'b0);
    txn("beq",  7'h63, 3'd0, 7'h00, 32'd9, 32'd9, 32'h20, 32'h100, 0, 1'b0);
    txn("bne",  7'h63, 3'd1, 7'h00, 32'd9, 32'd9, 32'h20, 32'h100, 0, 1'b0);
    txn("beqn", 7'h63, 3'd0, 7'h00, 32'd9, 32'd8, 32'h20, 32'h100, 0, 1'b0);
    txn("sub_bp", 7'h33, 3'd0, 7'h20, 32'd3, 32'd5, 32'd0, 32'd0, 4, 1'b0);
    txn("ill",  7'h03, 3'd0, 7'h00, 32'd1, 32'd2, 32'd3, 32'd4, 0, 1'b1);
    txn("addi", 7'h13, 3'd0, 7'h55, 32'hFFFFFFFF, 32'd9, 32'd1, 32'd0, 1, 1'b0);

    // Reset during MUL EXEC drops the transaction.
    in_valid = 1; opcode = 7'h33; funct3 = 0; funct7 = 7'h01;
    rs1_val = 32'd11; rs2_val = 32'd13;
    tick();
    in_valid = 0;
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk_reset_outputs("mid_rst");
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("dropped_no_resp", 32'(out_valid), 32'd0);
    end
    out_ready = 0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op, f7;
      logic [2:0] f3;
      logic [31:0] r1, r2, im, p;
      int k;
      k = $urandom_range(0, 7);
      r1 = $urandom; r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      im = $urandom; p = $urandom;
      f7 = 7'h00; f3 = 3'd0; op = 7'h33;
      case (k)
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        3: begin op = 7'h13; f7 = 7'($urandom); end
        4: op = 7'h63;
        5: begin op = 7'h63; f3 = 3'd1; end
        6: begin op = 7'h33; f3 = 3'($urandom_range(1, 7)); end
        default: begin op = 7'h63; f3 = 3'($urandom_range(2, 7)); end
      endcase
      txn("rand", op, f3, f7, r1, r2, im, p, $urandom_range(0, 2), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
